kb_race_ctrl: RTL and testbench

Race-phase sequencer for the drag-racing game. It consumes the registered keyboard key-state vector {W,S,K,Shift,Enter} and steps through arm, start-light countdown, race timing, finish and false-start handling. It drives the start lights, a go strobe level and the race timer to the game-logic and display blocks.

---
 rtl/kb_race_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_kb_race_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/kb_race_ctrl.sv
// kb_race_ctrl
// Race-phase sequencer for the drag-racing game: arm, start-light countdown,
// race timing, finish and false-start handling, driven by the registered
// keyboard key-state vector.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   kb_key_pressed {W,S,K,Shift,Enter}, bit4=W .. bit0=Enter, level = key held
//   finish         car crossed the line (level or pulse)
//   state          FSM state code (IDLE=0 ARMED=1 COUNTDOWN=2 RACE=3 DONE=4 FAULT=5)
//   lights         start lights, thermometer filling from bit0
//   go             high while in RACE
//   false_start    high while in FAULT
//   race_time      elapsed race time in TIME_CYCLES units, saturating
//   timeout        race ended by race_time saturation
//
// Optional feature macro: RACE_TIMEOUT_EN
//   defined   : race_time reaching all-ones ends the race (DONE, timeout=1)
//   undefined : race_time saturates, FSM stays in RACE, timeout is always 0

module kb_race_ctrl #(
    parameter int unsigned TICK_CYCLES = 65_000_000,
    parameter int unsigned TIME_CYCLES = 650_000,
    parameter int unsigned LIGHTS      = 3,
    parameter int unsigned TIME_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            kb_key_pressed,
    input  logic                  finish,
    output logic [2:0]            state,
    output logic [LIGHTS-1:0]     lights,
    output logic                  go,
    output logic                  false_start,
    output logic [TIME_WIDTH-1:0] race_time,
    output logic                  timeout
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned TIME_W = (TIME_CYCLES > 1) ? $clog2(TIME_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [TIME_W-1:0] TIME_LAST = TIME_W'(TIME_CYCLES - 1);

`ifdef RACE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARMED     = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_RACE      = 3'd3,
        S_DONE      = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [TICK_W-1:0]     tick_cnt;
    logic [TIME_W-1:0]     time_cnt;
    logic                  enter_q, k_q;
    logic                  enter_rise, k_rise, key_w;
    logic                  tick, time_wrap;
    logic [LIGHTS-1:0]     lights_d;
    logic                  go_d, false_start_d, timeout_d;
    logic [TIME_WIDTH-1:0] race_time_d, race_time_inc;

    // S and Shift belong to the gear logic elsewhere.
    logic unused_keys;
    assign unused_keys = kb_key_pressed[3] ^ kb_key_pressed[1];

    assign key_w      = kb_key_pressed[4];
    // Edge registers clear in reset, so a key held through reset release
    // is seen as a rise on the first clock.
    assign enter_rise = kb_key_pressed[0] & ~enter_q;
    assign k_rise     = kb_key_pressed[2] & ~k_q;

    assign tick          = (tick_cnt == TICK_LAST);
    assign time_wrap     = (state_q == S_RACE) && (time_cnt == TIME_LAST);
    assign race_time_inc = (race_time == '1) ? race_time : race_time + 1'b1;

    assign state = state_q;

    always_comb begin
        state_d       = state_q;
        lights_d      = lights;
        go_d          = go;
        false_start_d = false_start;
        race_time_d   = race_time;
        timeout_d     = timeout;

        if (k_rise && state_q != S_IDLE) begin
            // Abort outranks W, finish and tick in the same cycle.
            state_d       = S_IDLE;
            lights_d      = '0;
            go_d          = 1'b0;
            false_start_d = 1'b0;
            race_time_d   = '0;
            timeout_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    lights_d      = '0;
                    go_d          = 1'b0;
                    false_start_d = 1'b0;
                    race_time_d   = '0;
                    timeout_d     = 1'b0;
                    if (enter_rise) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (tick) begin
                        state_d  = S_COUNTDOWN;
                        lights_d = '0;
                    end
                end
                S_COUNTDOWN: begin
                    if (key_w) begin
                        state_d       = S_FAULT;
                        false_start_d = 1'b1;
                    end else if (tick) begin
                        if (lights == '1) begin
                            state_d  = S_RACE;
                            lights_d = '0;
                            go_d     = 1'b1;
                        end else begin
                            lights_d = {lights[LIGHTS-2:0], 1'b1};
                        end
                    end
                end
                S_RACE: begin
                    if (finish) begin
                        state_d = S_DONE;
                        go_d    = 1'b0;
                    end else if (time_wrap) begin
                        race_time_d = race_time_inc;
                        if (TIMEOUT_EN && race_time_inc == '1) begin
                            state_d   = S_DONE;
                            go_d      = 1'b0;
                            timeout_d = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (enter_rise) begin
                        state_d     = S_IDLE;
                        race_time_d = '0;
                        timeout_d   = 1'b0;
                    end
                end
                S_FAULT: begin
                    if (enter_rise) begin
                        state_d       = S_IDLE;
                        lights_d      = '0;
                        false_start_d = 1'b0;
                    end
                end
                default: begin
                    state_d       = S_IDLE;
                    lights_d      = '0;
                    go_d          = 1'b0;
                    false_start_d = 1'b0;
                    race_time_d   = '0;
                    timeout_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lights      <= '0;
            go          <= 1'b0;
            false_start <= 1'b0;
            race_time   <= '0;
            timeout     <= 1'b0;
            tick_cnt    <= '0;
            time_cnt    <= '0;
            enter_q     <= 1'b0;
            k_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            lights      <= lights_d;
            go          <= go_d;
            false_start <= false_start_d;
            race_time   <= race_time_d;
            timeout     <= timeout_d;
            enter_q     <= kb_key_pressed[0];
            k_q         <= kb_key_pressed[2];
            // Tick prescaler restarts on every state entry.
            if (state_d != state_q || tick) tick_cnt <= '0;
            else                            tick_cnt <= tick_cnt + 1'b1;
            // Time prescaler only advances while remaining in RACE.
            if (state_q == S_RACE && state_d == S_RACE && !time_wrap)
                time_cnt <= time_cnt + 1'b1;
            else
                time_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_kb_race_ctrl.sv
// tb_kb_race_ctrl
// Directed testbench for kb_race_ctrl (TICK_CYCLES=4, TIME_CYCLES=2, LIGHTS=3).
// A 16-bit timer instance runs the table and hand sequences; a 4-bit timer
// instance covers race_time saturation and the RACE_TIMEOUT_EN behaviour.

module tb_kb_race_ctrl;

    localparam logic [4:0] K_NONE  = 5'b00000;
    localparam logic [4:0] K_ENTER = 5'b00001;
    localparam logic [4:0] K_K     = 5'b00100;
    localparam logic [4:0] K_W     = 5'b10000;

`ifdef RACE_TIMEOUT_EN
    localparam logic [2:0] EXP4_ST = 3'd4;
    localparam logic       EXP4_TO = 1'b1;
    localparam logic       EXP4_GO = 1'b0;
`else
    localparam logic [2:0] EXP4_ST = 3'd3;
    localparam logic       EXP4_TO = 1'b0;
    localparam logic       EXP4_GO = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  kb = '0;
    logic        fin = 1'b0;
    logic [2:0]  st, li;
    logic        go, fs, to;
    logic [15:0] rt;

    logic [4:0]  kb4 = '0;
    logic        fin4 = 1'b0;
    logic [2:0]  st4, li4;
    logic        go4, fs4, to4;
    logic [3:0]  rt4;

    always #5 clk = ~clk;

    kb_race_ctrl #(.TICK_CYCLES(4), .TIME_CYCLES(2), .LIGHTS(3), .TIME_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .kb_key_pressed(kb), .finish(fin),
        .state(st), .lights(li), .go(go), .false_start(fs),
        .race_time(rt), .timeout(to)
    );

    kb_race_ctrl #(.TICK_CYCLES(4), .TIME_CYCLES(2), .LIGHTS(3), .TIME_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .kb_key_pressed(kb4), .finish(fin4),
        .state(st4), .lights(li4), .go(go4), .false_start(fs4),
        .race_time(rt4), .timeout(to4)
    );

    typedef struct {
        logic [4:0]  kb;
        logic        fin;
        int unsigned n;
        logic [2:0]  st;
        logic [2:0]  li;
        logic        go;
        logic        fs;
        logic [15:0] rt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add(input logic [4:0] k, input logic f, input int unsigned n,
                       input logic [2:0] s, input logic [2:0] l, input logic g,
                       input logic x, input logic [15:0] r);
        vec_t v;
        v.kb = k; v.fin = f; v.n = n; v.st = s; v.li = l; v.go = g; v.fs = x; v.rt = r;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic [2:0] s, input logic [2:0] l,
                             input logic g, input logic x, input logic [15:0] r);
        check({tag, ".state"}, 32'(st), 32'(s));
        check({tag, ".lights"}, 32'(li), 32'(l));
        check({tag, ".go"}, 32'(go), 32'(g));
        check({tag, ".false_start"}, 32'(fs), 32'(x));
        check({tag, ".race_time"}, 32'(rt), 32'(r));
        check({tag, ".timeout"}, 32'(to), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   kb              fin n   st   lights  go  fs  race_time
        add(K_NONE,        1'b0, 1,  3'd0, 3'b000, 0, 0, 16'd0);  // idle after reset
        add(K_ENTER,       1'b0, 1,  3'd1, 3'b000, 0, 0, 16'd0);  // arm
        add(K_NONE,        1'b0, 3,  3'd1, 3'b000, 0, 0, 16'd0);  // still armed
        add(K_NONE,        1'b0, 1,  3'd2, 3'b000, 0, 0, 16'd0);  // countdown
        add(K_NONE,        1'b0, 4,  3'd2, 3'b001, 0, 0, 16'd0);
        add(K_NONE,        1'b0, 4,  3'd2, 3'b011, 0, 0, 16'd0);
        add(K_NONE,        1'b0, 4,  3'd2, 3'b111, 0, 0, 16'd0);
        add(K_NONE,        1'b0, 3,  3'd2, 3'b111, 0, 0, 16'd0);  // one short of go
        add(K_NONE,        1'b0, 1,  3'd3, 3'b000, 1, 0, 16'd0);  // race
        add(K_NONE,        1'b0, 20, 3'd3, 3'b000, 1, 0, 16'd10);
        add(K_NONE,        1'b1, 1,  3'd4, 3'b000, 0, 0, 16'd10); // finish
        add(K_NONE,        1'b0, 5,  3'd4, 3'b000, 0, 0, 16'd10); // time held
        add(K_ENTER,       1'b0, 1,  3'd0, 3'b000, 0, 0, 16'd0);  // back to idle
        add(K_ENTER,       1'b0, 3,  3'd0, 3'b000, 0, 0, 16'd0);  // held Enter, no new rise
        add(K_NONE,        1'b0, 1,  3'd0, 3'b000, 0, 0, 16'd0);
        add(K_ENTER,       1'b0, 1,  3'd1, 3'b000, 0, 0, 16'd0);
        add(K_NONE,        1'b0, 4,  3'd2, 3'b000, 0, 0, 16'd0);
        add(K_NONE,        1'b0, 8,  3'd2, 3'b011, 0, 0, 16'd0);
        add(K_W,           1'b0, 1,  3'd5, 3'b011, 0, 1, 16'd0);  // false start
        add(K_NONE,        1'b0, 4,  3'd5, 3'b011, 0, 1, 16'd0);  // lights frozen
        add(K_ENTER,       1'b0, 1,  3'd0, 3'b000, 0, 0, 16'd0);
        add(K_NONE,        1'b1, 1,  3'd0, 3'b000, 0, 0, 16'd0);  // finish ignored in idle
        add(K_ENTER,       1'b0, 1,  3'd1, 3'b000, 0, 0, 16'd0);
        add(K_NONE,        1'b0, 4,  3'd2, 3'b000, 0, 0, 16'd0);
        add(K_NONE,        1'b0, 16, 3'd3, 3'b000, 1, 0, 16'd0);
        add(K_NONE,        1'b0, 6,  3'd3, 3'b000, 1, 0, 16'd3);
        add(K_K,           1'b1, 1,  3'd0, 3'b000, 0, 0, 16'd0);  // abort beats finish
        add(K_NONE,        1'b0, 2,  3'd0, 3'b000, 0, 0, 16'd0);
        add(K_ENTER,       1'b0, 1,  3'd1, 3'b000, 0, 0, 16'd0);
        add(K_NONE,        1'b0, 4,  3'd2, 3'b000, 0, 0, 16'd0);
        add(K_NONE,        1'b0, 4,  3'd2, 3'b001, 0, 0, 16'd0);
        add(K_W | K_K,     1'b0, 1,  3'd0, 3'b000, 0, 0, 16'd0);  // abort beats W
        add(K_NONE,        1'b0, 1,  3'd0, 3'b000, 0, 0, 16'd0);

        // Power-on reset
        #1 reset = 1'b1;
        #2 check_all("por", 3'd0, 3'b000, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            kb  = vecs[i].kb;
            fin = vecs[i].fin;
            cycles(vecs[i].n);
            check_all($sformatf("v%0d", i), vecs[i].st, vecs[i].li, vecs[i].go,
                      vecs[i].fs, vecs[i].rt);
        end

        // Async reset mid-countdown, then Enter held through reset release
        kb = K_ENTER; cycles(1);
        check("ar.armed", 32'(st), 32'd1);
        kb = K_NONE; cycles(4);
        check("ar.countdown", 32'(st), 32'd2);
        cycles(9);
        check("ar.lights", 32'(li), 32'(3'b011));
        #3 reset = 1'b1;
        #1 check_all("ar.async", 3'd0, 3'b000, 1'b0, 1'b0, 16'd0);
        kb = K_ENTER;
        @(posedge clk);
        #1 check("ar.held", 32'(st), 32'd0);
        reset = 1'b0;
        cycles(1);
        check("ar.rearm", 32'(st), 32'd1);
        kb = K_NONE; cycles(4);
        check("ar.recount", 32'(st), 32'd2);
        cycles(16);
        check_all("ar.race", 3'd3, 3'b000, 1'b1, 1'b0, 16'd0);
        kb = K_K; cycles(1);
        check("ar.abort", 32'(st), 32'd0);
        kb = K_NONE; cycles(1);

        // 4-bit race timer: saturation / timeout
        kb4 = K_ENTER; cycles(1);
        check("t4.armed", 32'(st4), 32'd1);
        kb4 = K_NONE; cycles(20);
        check("t4.race", 32'(st4), 32'd3);
        cycles(29);
        check("t4.rt14", 32'(rt4), 32'd14);
        check("t4.st14", 32'(st4), 32'd3);
        cycles(1);
        check("t4.rt15", 32'(rt4), 32'd15);
        check("t4.state", 32'(st4), 32'(EXP4_ST));
        check("t4.timeout", 32'(to4), 32'(EXP4_TO));
        check("t4.go", 32'(go4), 32'(EXP4_GO));
        cycles(6);
        check("t4.rt_sat", 32'(rt4), 32'd15);
        check("t4.state_hold", 32'(st4), 32'(EXP4_ST));
        check("t4.timeout_hold", 32'(to4), 32'(EXP4_TO));
        kb4 = K_K; cycles(1);
        check("t4.abort_st", 32'(st4), 32'd0);
        check("t4.abort_rt", 32'(rt4), 32'd0);
        check("t4.abort_to", 32'(to4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
